trace_capture: RTL

TRACE_CAPTURE -- requirements
Module: trace_capture

---
 rtl/trace_capture_pkg.sv | 22 ++
 rtl/trace_fifo.sv | 68 ++++++
 rtl/trace_capture.sv | 137 +++++++++++++
 3 files changed

// File: rtl/trace_capture_pkg.sv
// Shared definitions for the trace capture block.
//   state_e      : capture FSM state encoding (also driven on the state port)
//   REC_W        : width of one trace record {ins, rd2, wb}
//   FIELD_W      : width of each record field
//   *_LSB        : bit offsets of the record fields inside a record
// Optional feature macro (used by trace_capture): TRACE_CAPTURE_NOP_FILTER_EN
package trace_capture_pkg;

    typedef enum logic [1:0] {
        StIdle    = 2'd0,
        StArmed   = 2'd1,
        StCapture = 2'd2,
        StDone    = 2'd3
    } state_e;

    localparam int unsigned FIELD_W = 32;
    localparam int unsigned REC_W   = 96;
    localparam int unsigned INS_LSB = 64;
    localparam int unsigned RD2_LSB = 32;
    localparam int unsigned WB_LSB  = 0;

endpackage

// File: rtl/trace_fifo.sv
// Show-ahead trace FIFO.
//   clk, rst_n : clock, asynchronous active-low reset (storage is not reset)
//   clear      : synchronous flush of pointers and occupancy
//   push/wdata : write one record; accepted when not full or when popping the same cycle
//   pop        : remove head record; ignored when empty
//   rdata      : head record, combinational from storage
//   empty/full : occupancy flags
module trace_fifo
    import trace_capture_pkg::*;
#(
    parameter int unsigned DEPTH = 64
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clear,
    input  logic             push,
    input  logic [REC_W-1:0] wdata,
    input  logic             pop,
    output logic [REC_W-1:0] rdata,
    output logic             empty,
    output logic             full
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW + 1)'(DEPTH);

    logic [REC_W-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
    logic [AW:0]      count_q;
    logic             do_push, do_pop;

    assign empty = (count_q == '0);
    assign full  = (count_q == FULL_CNT);

    // A pop frees a slot in the same cycle, so a push into a full FIFO still fits.
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);

    assign rdata = mem[rd_ptr_q];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else if (clear) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            // DEPTH is a power of two, so pointers wrap naturally.
            if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
            if (do_push && !do_pop) begin
                count_q <= count_q + 1'b1;
            end else if (do_pop && !do_push) begin
                count_q <= count_q - 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (do_push && !clear) begin
            mem[wr_ptr_q] <= wdata;
        end
    end

endmodule

// File: rtl/trace_capture.sv
// Triggered instruction-trace capture.
//   clk, rst_n            : clock, asynchronous active-low reset
//   in_valid, ins/rd2/wb  : retired-instruction record from the core
//   arm                   : pulse to start watching for the trigger
//   trig_any, trig_ins    : trigger on first valid record, or on ins == trig_ins
//   clear                 : pulse to flush FIFO and counters and return to IDLE
//   rd_valid/rd_ready     : head record handshake; rd_data = {ins, rd2, wb}
//   state                 : IDLE=0, ARMED=1, CAPTURE=2, DONE=3
//   drop_cnt              : saturating count of records lost to a full FIFO
// Optional feature: define TRACE_CAPTURE_NOP_FILTER_EN to ignore records whose ins is zero
// (not stored, not counted, never trigger).
module trace_capture
    import trace_capture_pkg::*;
#(
    parameter int unsigned DEPTH = 64,
    parameter int unsigned LIMIT = 43
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    input  logic [FIELD_W-1:0] ins,
    input  logic [FIELD_W-1:0] rd2,
    input  logic [FIELD_W-1:0] wb,
    input  logic               arm,
    input  logic               trig_any,
    input  logic [FIELD_W-1:0] trig_ins,
    input  logic               clear,
    output logic               rd_valid,
    input  logic               rd_ready,
    output logic [REC_W-1:0]   rd_data,
    output logic [1:0]         state,
    output logic [15:0]        drop_cnt
);

    localparam logic [15:0] LIMIT16 = 16'(LIMIT);

    state_e           state_q, state_d;
    logic [15:0]      rec_cnt_q, rec_cnt_d;
    logic [15:0]      drop_q, drop_d;
    logic             rec_valid, offer, push, pop;
    logic             fifo_empty, fifo_full;
    logic [REC_W-1:0] rec;

    always_comb begin
        rec = '0;
        rec[INS_LSB +: FIELD_W] = ins;
        rec[RD2_LSB +: FIELD_W] = rd2;
        rec[WB_LSB  +: FIELD_W] = wb;
    end

`ifdef TRACE_CAPTURE_NOP_FILTER_EN
    assign rec_valid = in_valid && (ins != '0);
`else
    assign rec_valid = in_valid;
`endif

    assign rd_valid = !fifo_empty;
    assign pop      = rd_valid && rd_ready;

    always_comb begin
        state_d   = state_q;
        rec_cnt_d = rec_cnt_q;
        offer     = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (arm) begin
                    state_d   = StArmed;
                    rec_cnt_d = '0;
                end
            end
            StArmed: begin
                // The triggering record is itself record 1 of the run.
                if (rec_valid && (trig_any || (ins == trig_ins))) begin
                    offer     = 1'b1;
                    rec_cnt_d = 16'd1;
                    state_d   = (LIMIT16 == 16'd1) ? StDone : StCapture;
                end
            end
            StCapture: begin
                if (rec_valid) begin
                    offer     = 1'b1;
                    rec_cnt_d = rec_cnt_q + 16'd1;
                    if ((rec_cnt_q + 16'd1) == LIMIT16) state_d = StDone;
                end
            end
            StDone: begin
                if (arm) begin
                    state_d   = StArmed;
                    rec_cnt_d = '0;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // Dropped records still count toward LIMIT; only storage is skipped.
    assign push = offer && (!fifo_full || pop);

    always_comb begin
        drop_d = drop_q;
        if (offer && !push && (drop_q != 16'hFFFF)) drop_d = drop_q + 16'd1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= StIdle;
            rec_cnt_q <= '0;
            drop_q    <= '0;
        end else if (clear) begin
            state_q   <= StIdle;
            rec_cnt_q <= '0;
            drop_q    <= '0;
        end else begin
            state_q   <= state_d;
            rec_cnt_q <= rec_cnt_d;
            drop_q    <= drop_d;
        end
    end

    assign state    = state_q;
    assign drop_cnt = drop_q;

    trace_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .clear (clear),
        .push  (push),
        .wdata (rec),
        .pop   (pop),
        .rdata (rd_data),
        .empty (fifo_empty),
        .full  (fifo_full)
    );

endmodule
